// File: rtl/multiplier_arbiter_pkg.sv
// mult_arb_pkg: shared FSM encodings and width helpers for the multiplier arbiter
package mult_arb_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESPOND = 3'd4
  } state_t;
  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction
endpackage

// File: rtl/multiplier_arbiter_if.sv
// multiplier_arbiter_if: client request/response bus plus multiplier control/datapath links
// master: clients and multiplier (drive req*, mult_done, mult_product); slave: the arbiter
interface multiplier_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
);
  localparam int PROD_W = prod_w(WIDTH);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       resp_valid;
  logic                     resp_err;
  logic [PROD_W-1:0]        resp_product;
  logic                     busy;
  logic                     mult_start;
  logic                     mult_clear;
  logic [WIDTH-1:0]         mult_md;
  logic [WIDTH-1:0]         mult_mr;
  logic                     mult_done;
  logic [PROD_W-1:0]        mult_product;
  modport master (
    output req, req_a, req_b, mult_done, mult_product,
    input  ack, resp_valid, resp_err, resp_product, busy, mult_start, mult_clear, mult_md, mult_mr
  );
  modport slave (
    input  req, req_a, req_b, mult_done, mult_product,
    output ack, resp_valid, resp_err, resp_product, busy, mult_start, mult_clear, mult_md, mult_mr
  );
endinterface

// File: rtl/multiplier_arbiter_rr_picker.sv
// rr_picker: rotate-priority encoder, searching from ptr_i+1 upward with wrap
// req_i: request levels; ptr_i: last winner; any_o: some request set; idx_o: winner index
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               any_o,
  output logic [IW-1:0]      idx_o
);
  logic [IW-1:0] j;
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    j = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin sharing of one shift-add multiplier among NUM_REQ clients
// clk/rst: clock and synchronous active-low reset; bus: client req/ack/resp and multiplier links
module multiplier_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  multiplier_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam int PW = prod_w(WIDTH);
  state_t state_q, state_d;
  logic [IW-1:0] win_q, ptr_q, pick;
  logic any, err_q, timeout;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] md_q, mr_q;
  logic [PW-1:0] prod_q;
  logic [NUM_REQ-1:0] win_oh;
  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (.req_i(bus.req), .ptr_i(ptr_q), .any_o(any), .idx_o(pick));
  // WAIT lasts at most TIMEOUT+1 cycles, so an aborted response lands TIMEOUT+2 after ack
  assign timeout = cnt_q == CW'(TIMEOUT);
  assign win_oh = NUM_REQ'(1) << win_q;
  always_comb begin
    state_d = state_q == S_IDLE    ? (any ? S_LAUNCH : S_IDLE) :
              state_q == S_LAUNCH  ? S_WAIT :
              state_q == S_WAIT    ? (bus.mult_done ? S_CAPTURE : timeout ? S_RESPOND : S_WAIT) :
              state_q == S_CAPTURE ? S_RESPOND : S_IDLE;
  end
  assign bus.ack          = state_q == S_LAUNCH ? win_oh : '0;
  assign bus.mult_start   = state_q == S_LAUNCH;
  assign bus.resp_valid   = state_q == S_RESPOND ? win_oh : '0;
  assign bus.resp_err     = state_q == S_RESPOND && err_q;
  assign bus.mult_clear   = state_q == S_RESPOND && err_q;
  assign bus.resp_product = prod_q;
  assign bus.busy         = state_q != S_IDLE;
  assign bus.mult_md      = md_q;
  assign bus.mult_mr      = mr_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      win_q   <= '0;
      md_q    <= '0;
      mr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= state_q == S_WAIT ? cnt_q + 1'b1 : '0;
      if (state_q == S_IDLE && any) begin
        win_q <= pick;
        ptr_q <= pick;
        md_q  <= bus.req_a[int'(pick)*WIDTH +: WIDTH];
        mr_q  <= bus.req_b[int'(pick)*WIDTH +: WIDTH];
        err_q <= 1'b0;
      end
      if (state_q == S_WAIT && !bus.mult_done && timeout) begin
        err_q  <= 1'b1;
        prod_q <= '0;
      end
      // the multiplier's last shift lands on the edge leaving its done state
      if (state_q == S_CAPTURE) prod_q <= bus.mult_product;
    end
  end
endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter: table-driven and directed checks of the shared multiplier arbiter
module tb_multiplier_arbiter;
  import mult_arb_pkg::*;
  localparam int W = 4, N = 4, TO = 64;
  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    int          win;
    logic [7:0]  prod;
    int          lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  int tests = 0, fails = 0, cyc = 0, done_cyc = -100, mcnt = 0, mlat = 3, ack3 = 0;
  vec_t tv[9];
  always #5 clk = ~clk;
  multiplier_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
  multiplier_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mult_done) done_cyc <= cyc;
    if (bus.ack[3]) ack3 <= ack3 + 1;
  end
  always @(posedge clk) begin
    if (!rst) begin
      mcnt <= 0;
      bus.mult_done <= 1'b0;
      bus.mult_product <= '0;
    end else begin
      bus.mult_done <= 1'b0;
      if (bus.mult_done) bus.mult_product <= 8'(bus.mult_md) * 8'(bus.mult_mr);
      if (bus.mult_start) begin
        mcnt <= mlat;
        bus.mult_product <= '0;
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !stall) bus.mult_done <= 1'b1;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(input string name);
    int n = 0;
    do begin tick(); n++; end while (bus.ack == '0 && n < 20);
    if (bus.ack == '0) chk({name, "_ack_timeout"}, 0, 1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, bus.ack, 0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_resp_err"}, bus.resp_err, 0);
    chk({tag, "_resp_product"}, bus.resp_product, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_mult_start"}, bus.mult_start, 0);
    chk({tag, "_mult_clear"}, bus.mult_clear, 0);
    chk({tag, "_mult_md"}, bus.mult_md, 0);
    chk({tag, "_mult_mr"}, bus.mult_mr, 0);
  endtask
  task automatic run_op(input string tag, input logic [3:0] r, input logic [15:0] a, input logic [15:0] b,
                        input int win, input logic [7:0] prod);
    int t0, n;
    bus.req = r;
    bus.req_a = a;
    bus.req_b = b;
    t0 = cyc;
    wait_ack(tag);
    chk({tag, "_ack"}, bus.ack, 1 << win);
    chk({tag, "_ack_lat"}, cyc - t0, 1);
    chk({tag, "_start"}, bus.mult_start, 1);
    chk({tag, "_busy"}, bus.busy, 1);
    n = 0;
    do begin tick(); n++; end while (bus.resp_valid == '0 && n < 40);
    chk({tag, "_resp_valid"}, bus.resp_valid, 1 << win);
    chk({tag, "_product"}, bus.resp_product, prod);
    chk({tag, "_err"}, bus.resp_err, 0);
    chk({tag, "_resp_lat"}, cyc - done_cyc, 2);
    tick();
    chk({tag, "_valid_pulse"}, bus.resp_valid, 0);
  endtask
  initial begin
    int ta, n, clears, base;
    tv[0] = '{4'b0001, 16'h0007, 16'h0005, 0, 8'd35, 1};
    tv[1] = '{4'b1111, 16'hC0F9, 16'hB9FD, 1, 8'd225, 3};
    tv[2] = '{4'b1111, 16'hC0F9, 16'hB9FD, 2, 8'd0, 5};
    tv[3] = '{4'b1111, 16'hC0F9, 16'hB9FD, 3, 8'd132, 2};
    tv[4] = '{4'b1111, 16'hC0F9, 16'hB9FD, 0, 8'd117, 4};
    tv[5] = '{4'b0110, 16'h0A60, 16'h0470, 1, 8'd42, 1};
    tv[6] = '{4'b0110, 16'h0A60, 16'h0470, 2, 8'd40, 2};
    tv[7] = '{4'b0110, 16'h0A60, 16'h0470, 1, 8'd42, 3};
    tv[8] = '{4'b0110, 16'h0A60, 16'h0470, 2, 8'd40, 6};
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      mlat = tv[i].lat;
      run_op($sformatf("vec%0d", i), tv[i].req, tv[i].a, tv[i].b, tv[i].win, tv[i].prod);
    end
    stall = 1'b1;
    bus.req = 4'b0001;
    bus.req_a = 16'h0005;
    bus.req_b = 16'h0005;
    wait_ack("to");
    chk("to_ack", bus.ack, 4'b0001);
    ta = cyc;
    clears = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (bus.mult_clear) clears++;
    end while (bus.resp_valid == '0 && n < 100);
    chk("to_lat", cyc - ta, TO + 2);
    chk("to_resp_valid", bus.resp_valid, 4'b0001);
    chk("to_err", bus.resp_err, 1);
    chk("to_product", bus.resp_product, 0);
    bus.req = '0;
    tick();
    if (bus.mult_clear) clears++;
    chk("to_clear_count", clears, 1);
    chk("to_idle_busy", bus.busy, 0);
    stall = 1'b0;
    mlat = 8;
    base = ack3;
    bus.req = 4'b0010;
    bus.req_a = 16'h0030;
    bus.req_b = 16'h0040;
    wait_ack("wd");
    chk("wd_ack", bus.ack, 4'b0010);
    bus.req = '0;
    tick();
    bus.req = 4'b1000;
    bus.req_a = 16'hF030;
    tick();
    bus.req = '0;
    n = 0;
    do begin tick(); n++; end while (bus.resp_valid == '0 && n < 40);
    chk("wd_resp_valid", bus.resp_valid, 4'b0010);
    chk("wd_product", bus.resp_product, 12);
    repeat (3) tick();
    chk("wd_busy", bus.busy, 0);
    chk("wd_ack3_count", ack3 - base, 0);
    bus.req = 4'b0100;
    bus.req_a = 16'h0200;
    bus.req_b = 16'h0300;
    wait_ack("rs");
    chk("rs_ack", bus.ack, 4'b0100);
    bus.req = '0;
    repeat (2) tick();
    chk("rs_in_wait_busy", bus.busy, 1);
    rst = 1'b0;
    tick();
    chk_zero("midreset");
    rst = 1'b1;
    mlat = 2;
    run_op("post_reset", 4'b1000, 16'hD000, 16'hE000, 3, 8'd182);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
